// File: rtl/binary_swell_3x3_pkg.sv
// Shared definitions for the binary swell (dilation) window stage:
// FSM encoding, fill constants and the counter-width helper.
package swell_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Fill bits, replicated to pixel width at the point of use
  localparam logic FG_ALL_ONES = 1'b1;
  localparam logic BG_ZERO     = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/binary_swell_3x3_if.sv
// Pixel bus between the line buffer, the swell window stage and the output stage.
interface binary_swell_3x3_if #(parameter int DW = 24);
  logic          i_de;
  logic [DW-1:0] i_row_bot;
  logic [DW-1:0] i_row_mid;
  logic [DW-1:0] i_row_top;
  logic          o_flush_de;
  logic          o_de;
  logic [DW-1:0] o_dout;
  logic          o_sof;
  logic          o_busy;
  logic [7:0]    o_err_cnt;

  modport slave (
    input  i_de, i_row_bot, i_row_mid, i_row_top,
    output o_flush_de, o_de, o_dout, o_sof, o_busy, o_err_cnt
  );

  modport master (
    output i_de, i_row_bot, i_row_mid, i_row_top,
    input  o_flush_de, o_de, o_dout, o_sof, o_busy, o_err_cnt
  );
endinterface

// File: rtl/binary_swell_3x3_window.sv
// 3x3 binary window: two column registers per row plus border mask and OR reduction.
// SWELL_CROSS_SE_EN selects the plus-shaped element; default is the full 3x3 square.
module swell_window3x3 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_shift,
  input  logic [2:0] i_tap,     // [0]=top, [1]=mid, [2]=bot, column c
  input  logic       i_mask_l,
  input  logic       i_mask_r,
  input  logic       i_mask_t,
  input  logic       i_mask_b,
  output logic       o_hit
);

  logic [2:0] r_c1, r_c2;
  logic [2:0] w_rowm, w_l, w_c, w_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c1 <= '0;
      r_c2 <= '0;
    end else if (i_shift) begin
      r_c2 <= r_c1;
      r_c1 <= i_tap;
    end
  end

  // Centre column is c-1 (r_c1); right column is the live tap
  assign w_rowm = {~i_mask_b, 1'b1, ~i_mask_t};
  assign w_l    = r_c2  & w_rowm & {3{~i_mask_l}};
  assign w_c    = r_c1  & w_rowm;
  assign w_r    = i_tap & w_rowm & {3{~i_mask_r}};

`ifdef SWELL_CROSS_SE_EN
  assign o_hit = (|w_c) | w_l[1] | w_r[1];
`else
  assign o_hit = |{w_l, w_c, w_r};
`endif

endmodule

// File: rtl/binary_swell_3x3.sv
// Binary swell stage: counters, frame FSM with bottom-row flush, registered outputs.
// Structuring element chosen by SWELL_CROSS_SE_EN (see swell_window3x3).
module binary_swell_3x3
  import swell_pkg::*;
#(
  parameter int IMG_WIDTH_DATA = 24,
  parameter int IMG_WIDTH_LINE = 800,
  parameter int IMG_HEIGHT     = 600
) (
  input  logic               clk,
  input  logic               reset_n,
  binary_swell_3x3_if.slave  bus
);

  localparam int CW = clog2(IMG_WIDTH_LINE);
  localparam int RW = clog2(IMG_HEIGHT + 1);
  localparam int FW = clog2(IMG_WIDTH_LINE + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH_LINE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FCNT_W   = FW'(IMG_WIDTH_LINE);

  logic [1:0]                r_state;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic [FW-1:0]             r_fcnt;
  logic                      r_cf_pend, r_cf_vld, r_cf_top, r_cf_bot;
  logic                      r_de, r_sof;
  logic [IMG_WIDTH_DATA-1:0] r_dout;
  logic [7:0]                r_err;

  logic w_flush_de, w_strobe, w_col_last, w_pix_vld, w_out_vld, w_hit;
  logic w_mask_l, w_mask_r, w_mask_t, w_mask_b;

  // Flush strobes wait one clock so the previous line's column flush has a free slot
  assign w_flush_de = (r_state == ST_FLUSH) && !r_cf_pend && (r_fcnt != FCNT_W);
  assign w_strobe   = (bus.i_de && (r_state != ST_FLUSH)) || w_flush_de;
  assign w_col_last = (r_col == COL_LAST);
  assign w_pix_vld  = w_strobe && (r_col != '0) && (r_row != '0);
  assign w_out_vld  = w_pix_vld || r_cf_vld;

  assign w_mask_l = w_strobe && (r_col == CW'(1));
  assign w_mask_r = r_cf_vld;
  assign w_mask_t = r_cf_vld ? r_cf_top : (r_row == RW'(1));
  assign w_mask_b = r_cf_vld ? r_cf_bot : (r_state == ST_FLUSH);

  swell_window3x3 u_win (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_shift  (w_strobe),
    .i_tap    ({bus.i_row_bot[IMG_WIDTH_DATA-1], bus.i_row_mid[IMG_WIDTH_DATA-1],
                bus.i_row_top[IMG_WIDTH_DATA-1]}),
    .i_mask_l (w_mask_l),
    .i_mask_r (w_mask_r),
    .i_mask_t (w_mask_t),
    .i_mask_b (w_mask_b),
    .o_hit    (w_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_fcnt    <= '0;
      r_cf_pend <= 1'b0;
      r_cf_vld  <= 1'b0;
      r_cf_top  <= 1'b0;
      r_cf_bot  <= 1'b0;
      r_de      <= 1'b0;
      r_sof     <= 1'b0;
      r_dout    <= '0;
      r_err     <= '0;
    end else begin
      r_de   <= w_out_vld;
      r_dout <= (w_out_vld && w_hit) ? {IMG_WIDTH_DATA{FG_ALL_ONES}} : {IMG_WIDTH_DATA{BG_ZERO}};
      r_sof  <= w_pix_vld && (r_col == CW'(1)) && (r_row == RW'(1));

      // Row-dependent masks are captured here since r_row advances before the column flush
      r_cf_pend <= w_strobe && w_col_last;
      r_cf_vld  <= w_strobe && w_col_last && (r_row != '0);
      r_cf_top  <= (r_row == RW'(1));
      r_cf_bot  <= (r_state == ST_FLUSH);

      if (w_strobe) begin
        r_col <= w_col_last ? '0 : r_col + CW'(1);
        if (w_col_last && (r_state != ST_FLUSH)) r_row <= r_row + RW'(1);
      end

      if (bus.i_de && (r_state == ST_FLUSH) && (r_err != 8'hFF)) r_err <= r_err + 8'd1;

      case (r_state)
        ST_IDLE: if (bus.i_de) r_state <= ST_RUN;
        ST_RUN:  if (w_strobe && w_col_last && (r_row == ROW_LAST)) r_state <= ST_FLUSH;
        ST_FLUSH: begin
          if (w_flush_de) r_fcnt <= r_fcnt + FW'(1);
          if (r_cf_pend && (r_fcnt == FCNT_W)) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_fcnt  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_flush_de = w_flush_de;
  assign bus.o_de       = r_de;
  assign bus.o_dout     = r_dout;
  assign bus.o_sof      = r_sof;
  assign bus.o_busy     = (r_state == ST_FLUSH);
  assign bus.o_err_cnt  = r_err;

endmodule

// File: tb/tb_binary_swell_3x3.sv
// Directed bench for binary_swell_3x3 (W=4, H=3) with a line-buffer tap model and
// a neighbourhood golden model; out-of-frame taps are driven as foreground junk.
module tb_binary_swell_3x3;
  localparam int W = 4, H = 3, DW = 24, NF = 8;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  binary_swell_3x3_if #(.DW(DW)) bus ();

  binary_swell_3x3 #(.IMG_WIDTH_DATA(DW), .IMG_WIDTH_LINE(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  bit fimg [NF][H][W];
  int pix_cnt [NF];
  int fl_cnt  [NF];
  int sof_cnt [NF];
  int n_vec = 0, n_err = 0;
  int drv_f = 0, mon_f = 0, mon_pix = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit gold(input int f, input int r, input int c);
    bit h = 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
`ifdef SWELL_CROSS_SE_EN
        if (dr != 0 && dc != 0) continue;
`endif
        if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W && fimg[f][r+dr][c+dc]) h = 1'b1;
      end
    return h;
  endfunction

  // Output monitor: position tracked by counting o_de pulses within the frame
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_pix = 0;
      mon_f   = drv_f;
    end else if (mon_f < NF) begin
      if (bus.o_flush_de) begin
        fl_cnt[mon_f]++;
        chk("busy_in_flush", 64'(bus.o_busy), 64'd1);
      end
      if (bus.o_sof) sof_cnt[mon_f]++;
      if (bus.o_de) begin
        chk($sformatf("dout f%0d r%0d c%0d", mon_f, mon_pix / W, mon_pix % W), 64'(bus.o_dout),
            gold(mon_f, mon_pix / W, mon_pix % W) ? 64'(ONES) : 64'd0);
        chk($sformatf("sof f%0d p%0d", mon_f, mon_pix), 64'(bus.o_sof), 64'(mon_pix == 0));
        pix_cnt[mon_f]++;
        mon_pix++;
        if (mon_pix == W*H) begin
          mon_pix = 0;
          mon_f++;
        end
      end
    end
  end

  task automatic set_taps(input bit b, input bit m, input bit t);
    bus.i_row_bot = {b, (DW-1)'($urandom)};
    bus.i_row_mid = {m, (DW-1)'($urandom)};
    bus.i_row_top = {t, (DW-1)'($urandom)};
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_de"},    64'(bus.o_de),       64'd0);
    chk({pfx, "_dout"},  64'(bus.o_dout),     64'd0);
    chk({pfx, "_sof"},   64'(bus.o_sof),      64'd0);
    chk({pfx, "_flush"}, 64'(bus.o_flush_de), 64'd0);
    chk({pfx, "_busy"},  64'(bus.o_busy),     64'd0);
    chk({pfx, "_err"},   64'(bus.o_err_cnt),  64'd0);
  endtask

  // Drives one frame as the line buffer would; abort_at>0 pulses reset after that strobe
  task automatic drive_frame(input int f, input int abort_at, input bit inj);
    int n = 0, fc = 0, to = 0;
    drv_f = f;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        bus.i_de = 1'b1;
        set_taps(fimg[f][r][c], (r >= 1) ? fimg[f][r-1][c] : 1'b1, (r >= 2) ? fimg[f][r-2][c] : 1'b1);
        n++;
        if (n == abort_at) begin
          @(posedge clk);
          #1;
          chk("pre_rst_de", 64'(bus.o_de), 64'd1);
          reset_n = 1'b0;
          #1;
          chk_outputs_zero("rst_mid");
          bus.i_de = 1'b0;
          drv_f = f + 1;
          repeat (3) @(negedge clk);
          reset_n = 1'b1;
          return;
        end
      end
      if (r != H-1) begin
        @(negedge clk);
        bus.i_de = 1'b0;
        set_taps(1'b1, 1'b1, 1'b1);
      end
    end
    do begin
      @(negedge clk);
      if (!bus.o_busy) break;
      bus.i_de = inj;
      if (bus.o_flush_de && fc < W) begin
        set_taps(1'b1, fimg[f][H-1][fc], fimg[f][H-2][fc]);
        fc++;
      end else set_taps(1'b1, 1'b1, 1'b1);
      to++;
    end while (to < 3*W + 10);
    bus.i_de = 1'b0;
    chk($sformatf("flush_done f%0d", f), 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    bus.i_de = 1'b0;
    set_taps(1'b0, 1'b0, 1'b0);
    fimg[0][1][1] = 1'b1;
    fimg[1][0][0] = 1'b1;
    fimg[2][2][3] = 1'b1;
    fimg[4][0][3] = 1'b1;
    fimg[4][2][0] = 1'b1;
    for (int f = 5; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          fimg[f][r][c] = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < W; c++) fimg[3][1][c] = 1'b1;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    drive_frame(0, 0, 1'b0);
    drive_frame(1, 0, 1'b0);
    drive_frame(2, 0, 1'b1);
    chk("err_cnt", 64'(bus.o_err_cnt), 64'(W + 2));
    drive_frame(3, W + 3, 1'b0);
    chk("err_after_rst", 64'(bus.o_err_cnt), 64'd0);
    drive_frame(4, 0, 1'b0);
    drive_frame(5, 0, 1'b0);
    drive_frame(6, 0, 1'b0);
    drive_frame(7, 0, 1'b0);
    repeat (5) @(negedge clk);

    for (int f = 0; f < NF; f++) begin
      if (f == 3) continue;
      chk($sformatf("pix_cnt f%0d", f), 64'(pix_cnt[f]), 64'(W*H));
      chk($sformatf("flush_cnt f%0d", f), 64'(fl_cnt[f]), 64'(W));
      chk($sformatf("sof_cnt f%0d", f), 64'(sof_cnt[f]), 64'd1);
    end
    chk("frames_out", 64'(mon_f), 64'(NF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/binary_swell_3x3.md
Name: binary_swell_3x3

Overview:
- Window-and-dilate stage that sits directly downstream of the 3-row line buffer in the binary-image swell pipeline.
- Takes three vertically aligned row taps and builds a 3x3 window with column shift registers.
- Outputs the morphological dilation (OR over the structuring element), with frame-border masking and a bottom-row flush.
- Output feeds the video output / DMA stage.

Parameters:
- IMG_WIDTH_DATA, 24, pixel width in bits. A pixel is foreground when its MSB = 1.
- IMG_WIDTH_LINE, 800, active pixels per line (W), minimum 2.
- IMG_HEIGHT, 600, active lines per frame (H), minimum 2.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- i_de  in  1  pixel valid from the line buffer (its o_line_de).
- i_row_bot  in  IMG_WIDTH_DATA  newest row tap, row r+1.
- i_row_mid  in  IMG_WIDTH_DATA  row r, the window centre row.
- i_row_top  in  IMG_WIDTH_DATA  row r-1.
- o_flush_de  out  1  self-generated strobe; the integrator ORs it into the line buffer de during FLUSH.
- o_de  out  1  output pixel valid.
- o_dout  out  IMG_WIDTH_DATA  all-ones if any element of the window is foreground, else all-zeros.
- o_sof  out  1  high with the first o_de of each frame.
- o_busy  out  1  high while in FLUSH.

Behaviour:
- Reset: everything clears asynchronously. o_de=0, o_dout=0, o_sof=0, o_flush_de=0, o_busy=0, counters=0, shift registers=0, FSM=IDLE.
- Counters:
  - col counter counts 0..W-1 on each pixel strobe (i_de or o_flush_de).
  - in_row counter counts 0..H on the falling edge of the line, i.e. when col wraps.
- Binarise: each tap reduces to 1 bit (MSB). Two column registers per row give columns c-2, c-1, c.
- Window centre is (row r, column c-1). Output for centre column c-1 is produced on the strobe of input column c.
- Last column (c=W-1) is produced one clock after the line's final strobe (column flush). i_de must be low for at least 1 clock between lines; this is a precondition, and violations are undefined.
- Border masking (out-of-frame neighbours = 0):
  - left column masked when the centre column is 0;
  - right column masked during the column flush;
  - top row masked when the output row is 0;
  - bottom row masked during FLUSH.
- Vertical timing: input row 0 produces no output (primes the window). Output row k is emitted during input row k+1.
- Latency: o_de/o_dout are registered, 1 clock after the centre pixel's window completes. Each output line is exactly W pixels; each frame is exactly H lines.
- FSM:
  - IDLE: wait for i_de; go to RUN.
  - RUN: consume input rows. When in_row reaches H and the line ends, go to FLUSH.
  - FLUSH: o_busy=1. Drive o_flush_de for W consecutive clocks. Emit output row H-1 with the bottom row masked, then go to IDLE and clear counters.
  - i_de asserted during FLUSH is ignored and counted as an error. The next frame must wait until o_busy=0.
- o_sof pulses with output row 0, column 0.
- Reset mid-frame: immediate return to IDLE. No partial lines are emitted after reset.

Optional Feature:
- SWELL_CROSS_SE_EN defined: 4-connected plus-shaped structuring element. Corners are excluded; output = OR of the centre, N, S, E and W pixels.
- Not defined: full 3x3 square element (all 9 pixels ORed).
- Timing, latency and masking are identical in both cases.

Decomposition:
- Shared package swell_pkg:
  - FSM state encoding (IDLE, RUN, FLUSH);
  - constants FG_ALL_ONES and BG_ZERO;
  - the counter width function clog2.
- One natural sub-module: swell_window3x3 holds the 3x2 column shift registers plus the mask-and-OR reduction. The top level keeps the counters, FSM and output registers.

Test Plan:
- W=4, H=3, single foreground pixel at (1,1), rest zero -> output rows 0..2 are all ones in columns 0..2; column 3 is zero in every row.
- Foreground at corner (0,0) -> output ones only at (0,0),(0,1),(1,0),(1,1). Verifies top and left masking; no wrap from the previous line.
- Foreground at (2,3) in the last row and column -> ones at (1,2),(1,3),(2,2),(2,3). Requires the FLUSH path with o_flush_de high for exactly 4 clocks and o_busy high during it.
- SWELL_CROSS_SE_EN defined, pixel at (1,1) -> ones at (0,1),(1,0),(1,1),(1,2),(2,1) only.
- reset_n pulsed low mid row 1 of a frame -> all outputs 0 in the same cycle. A new clean frame afterwards matches the golden model; o_sof fires once, at its row 0 column 0.
- Back-to-back frames with a 1-clock de gap between lines -> exactly W·H o_de pulses per frame, all matching the golden model.
